// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin owner selection for one shared down-counting
// interval timer. A granted requester gets its load value counted to zero,
// then a one-cycle done pulse. Dropping the request while counting aborts.
module counter_scheduler #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] load_val,
  input  logic                   hold,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic [CNT_W-1:0]       cnt_out,
  output logic [N_REQ-1:0]       done
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
  logic [PTR_W-1:0] r_idx, w_idx_nxt;
  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  logic [N_REQ-1:0] r_done, w_done_nxt;
  logic             r_busy, w_busy_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic             w_found;
  logic [PTR_W-1:0] w_pick;
  logic [PTR_W-1:0] w_cand;
  logic [PTR_W-1:0] w_idx_inc;

  // First pending request at or after the round-robin pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = PTR_W'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  // Pointer moves just past the owner that is releasing the counter.
  assign w_idx_inc = (r_idx == PTR_W'(N_REQ - 1)) ? '0 : r_idx + 1'b1;

  // Next-state and next-output logic; registers hold unless a transition applies.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_idx;
    w_grant_nxt = r_grant;
    w_busy_nxt  = r_busy;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_idx_nxt   = w_pick;
          w_grant_nxt = N_REQ'(1) << w_pick;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = load_val[w_pick*CNT_W +: CNT_W];
          w_state_nxt = S_COUNT;
        end else begin
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end
      end
      S_COUNT: begin
        if (!req[r_idx]) begin
          // Abort: release silently, no completion pulse.
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_ptr_nxt   = w_idx_inc;
          w_state_nxt = S_IDLE;
        end else if (hold) begin
          w_cnt_nxt   = r_cnt;
        end else if (r_cnt == '0) begin
          w_done_nxt  = r_grant;
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
          w_ptr_nxt   = w_idx_inc;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt   = r_cnt - 1'b1;
        end
      end
      S_DONE: begin
        // Single-cycle pulse; no arbitration here.
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_done  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_idx   <= w_idx_nxt;
      r_grant <= w_grant_nxt;
      r_busy  <= w_busy_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign grant   = r_grant;
  assign busy    = r_busy;
  assign cnt_out = r_cnt;
  assign done    = r_done;

endmodule
